jtdd_mcu_arb: RTL and testbench

JTDD_MCU_ARB -- requirements
Module: jtdd_mcu_arb

---
 rtl/jtdd_mcu_arb_pkg.sv | 15 +
 rtl/jtdd_mcu_arb.sv | 117 +++++++++++
 tb/tb_jtdd_mcu_arb.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtdd_mcu_arb_pkg.sv
// Shared definitions for the main-CPU / MCU shared RAM arbiter.
// State encoding and counter width used by jtdd_mcu_arb.
package jtdd_mcu_arb_pkg;

    localparam int CW = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HALTREQ = 3'd1,
        ST_GRANT   = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } state_t;

endpackage

// File: rtl/jtdd_mcu_arb.sv
// Shared RAM arbiter: halts the MCU, grants the window to the main CPU,
// holds it briefly after the request drops, and queues MCU NMIs.
module jtdd_mcu_arb
    import jtdd_mcu_arb_pkg::*;
#(
    parameter int HOLD    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstb,
    input  logic main_req,
    input  logic nmi_req,
    input  logic mcu_halted,
    output logic main_wait,
    output logic mcu_halt,
    output logic grant,
    output logic nmi_set,
    output logic tmo_err
);

    // Clamp both limits into the 8-bit counters; HOLD=0 acts as HOLD=1
    localparam int HOLD_CL = (HOLD < 1) ? 1 : ((HOLD > 256) ? 256 : HOLD);
    localparam int TMO_CL  = (TIMEOUT < 0) ? 0 :
                             ((TIMEOUT > 255) ? 255 : TIMEOUT);
    localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CL - 1);
    localparam logic [CW-1:0] TMO_LIM = CW'(TMO_CL);

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] tmo_cnt;
    logic [CW-1:0] tmo_nx;
    logic [CW-1:0] hold_cnt;
    logic [CW-1:0] hold_nx;
    logic          tmo_set;
    logic          nmi_q;
    logic          nmi_pend;
    logic          pend_nx;
    logic          nmi_rise;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state    <= ST_IDLE;
            tmo_cnt  <= '0;
            hold_cnt <= '0;
            tmo_err  <= 1'b0;
            nmi_q    <= 1'b0;
            nmi_pend <= 1'b0;
        end else begin
            state    <= state_nx;
            tmo_cnt  <= tmo_nx;
            hold_cnt <= hold_nx;
            tmo_err  <= tmo_err | tmo_set;
            nmi_q    <= nmi_req;
            nmi_pend <= pend_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tmo_nx   = tmo_cnt;
        hold_nx  = hold_cnt;
        tmo_set  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (main_req) begin
                    state_nx = ST_HALTREQ;
                    tmo_nx   = '0;
                end
            end
            ST_HALTREQ: begin
                if (mcu_halted) begin
                    state_nx = ST_GRANT;
                end else if (tmo_cnt >= TMO_LIM) begin
                    state_nx = ST_GRANT;
                    tmo_set  = 1'b1;
                end else begin
                    tmo_nx = tmo_cnt + 1'b1;
                end
            end
            ST_GRANT: begin
                if (!main_req) begin
                    state_nx = ST_HOLD;
                    hold_nx  = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (main_req) begin
                    state_nx = ST_GRANT;
                end else if (hold_cnt == '0) begin
                    state_nx = ST_RELEASE;
                end else begin
                    hold_nx = hold_cnt - 1'b1;
                end
            end
            ST_RELEASE: begin
                if (!mcu_halted) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign mcu_halt  = (state == ST_HALTREQ) ||
                       (state == ST_GRANT)   ||
                       (state == ST_HOLD);
    assign grant     = (state == ST_GRANT) || (state == ST_HOLD);
    assign main_wait = main_req & ~grant;

    // A fresh edge during the pulse cycle wins over the clear
    assign nmi_rise = nmi_req & ~nmi_q;
    assign nmi_set  = (state == ST_IDLE) & nmi_pend;
    assign pend_nx  = nmi_rise | (nmi_pend & ~nmi_set);

endmodule

// File: tb/tb_jtdd_mcu_arb.sv
// Directed bench for jtdd_mcu_arb (HOLD=8, TIMEOUT=255).
// Output vector o = {main_wait, mcu_halt, grant, nmi_set, tmo_err}.
module tb_jtdd_mcu_arb;

    logic clk = 1'b0;
    logic rstb;
    logic main_req;
    logic nmi_req;
    logic mcu_halted;
    logic main_wait;
    logic mcu_halt;
    logic grant;
    logic nmi_set;
    logic tmo_err;
    logic [4:0] o;

    int tests = 0;
    int fails = 0;

    jtdd_mcu_arb #(.HOLD(8), .TIMEOUT(255)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .main_req  (main_req),
        .nmi_req   (nmi_req),
        .mcu_halted(mcu_halted),
        .main_wait (main_wait),
        .mcu_halt  (mcu_halt),
        .grant     (grant),
        .nmi_set   (nmi_set),
        .tmo_err   (tmo_err)
    );

    always #5 clk = ~clk;

    assign o = {main_wait, mcu_halt, grant, nmi_set, tmo_err};

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    task automatic to_grant(input logic tmo);
        next;
        main_req   = 1'b1;
        mcu_halted = 1'b1;
        next;
        next;
        @(negedge clk);
        tests++;
        if (o !== {4'b0110, tmo}) begin
            fails++;
            $display("FAIL to_grant o=%b exp=%b", o, {4'b0110, tmo});
        end
    endtask

    task automatic drop_to_idle;
        logic done;
        done = 1'b0;
        next;
        main_req = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            next;
            @(negedge clk);
            tests++;
            if (nmi_set !== 1'b0) begin
                fails++;
                $display("FAIL drop_nmi k=%0d nmi_set=%b exp=0", k, nmi_set);
            end
            if (grant === 1'b0) done = 1'b1;
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL drop_timeout grant=%b exp=0", grant);
        end
        mcu_halted = 1'b0;
        next;
    endtask

    task automatic test_reset;
        rstb       = 1'b0;
        main_req   = 1'b0;
        nmi_req    = 1'b0;
        mcu_halted = 1'b0;
        #12;
        tests++;
        if (o !== 5'b00000) begin
            fails++;
            $display("FAIL reset o=%b exp=00000", o);
        end
        @(negedge clk);
        rstb = 1'b1;
    endtask

    task automatic test_grant;
        next;
        main_req = 1'b1;
        @(negedge clk);
        tests++;
        if (o !== 5'b10000) begin
            fails++;
            $display("FAIL grant_c0 o=%b exp=10000", o);
        end
        for (int c = 1; c <= 3; c++) begin
            next;
            if (c == 3) mcu_halted = 1'b1;
            @(negedge clk);
            tests++;
            if (o !== 5'b11000) begin
                fails++;
                $display("FAIL grant_c%0d o=%b exp=11000", c, o);
            end
        end
        next;
        @(negedge clk);
        tests++;
        if (o !== 5'b01100) begin
            fails++;
            $display("FAIL grant_c4 o=%b exp=01100", o);
        end
    endtask

    task automatic test_hold;
        for (int c = 5; c < 10; c++) next;
        next;
        main_req = 1'b0;
        @(negedge clk);
        tests++;
        if (o !== 5'b01100) begin
            fails++;
            $display("FAIL hold_fall o=%b exp=01100", o);
        end
        for (int k = 1; k <= 8; k++) begin
            next;
            @(negedge clk);
            tests++;
            if (o !== 5'b01100) begin
                fails++;
                $display("FAIL hold_k%0d o=%b exp=01100", k, o);
            end
        end
        for (int k = 9; k <= 10; k++) begin
            next;
            @(negedge clk);
            tests++;
            if (o !== 5'b00000) begin
                fails++;
                $display("FAIL hold_rel%0d o=%b exp=00000", k, o);
            end
        end
        mcu_halted = 1'b0;
        next;
        @(negedge clk);
        tests++;
        if (o !== 5'b00000) begin
            fails++;
            $display("FAIL hold_idle o=%b exp=00000", o);
        end
    endtask

    task automatic test_release_pending;
        to_grant(1'b0);
        next;
        main_req = 1'b0;
        for (int k = 4; k <= 11; k++) begin
            next;
            @(negedge clk);
            tests++;
            if (o !== 5'b01100) begin
                fails++;
                $display("FAIL relp_hold%0d o=%b exp=01100", k, o);
            end
        end
        next;
        main_req = 1'b1;
        for (int k = 12; k <= 14; k++) begin
            if (k > 12) next;
            @(negedge clk);
            tests++;
            if (o !== 5'b10000) begin
                fails++;
                $display("FAIL relp_rel%0d o=%b exp=10000", k, o);
            end
        end
        mcu_halted = 1'b0;
        next;
        @(negedge clk);
        tests++;
        if (o !== 5'b10000) begin
            fails++;
            $display("FAIL relp_idle o=%b exp=10000", o);
        end
        next;
        @(negedge clk);
        tests++;
        if (o !== 5'b11000) begin
            fails++;
            $display("FAIL relp_haltreq o=%b exp=11000", o);
        end
        mcu_halted = 1'b1;
        next;
        @(negedge clk);
        tests++;
        if (o !== 5'b01100) begin
            fails++;
            $display("FAIL relp_grant o=%b exp=01100", o);
        end
    endtask

    task automatic test_reassert;
        next;
        main_req = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) next;
            if (k == 3) main_req = 1'b1;
            @(negedge clk);
            tests++;
            if (o !== 5'b01100) begin
                fails++;
                $display("FAIL reassert_k%0d o=%b exp=01100", k, o);
            end
        end
        drop_to_idle();
        @(negedge clk);
        tests++;
        if (o !== 5'b00000) begin
            fails++;
            $display("FAIL reassert_idle o=%b exp=00000", o);
        end
    endtask

    task automatic test_nmi;
        to_grant(1'b0);
        for (int k = 0; k < 4; k++) begin
            next;
            nmi_req = (k % 2 == 0);
            @(negedge clk);
            tests++;
            if (o !== 5'b01100) begin
                fails++;
                $display("FAIL nmi_grant%0d o=%b exp=01100", k, o);
            end
        end
        drop_to_idle();
        nmi_req = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) next;
            @(negedge clk);
            tests++;
            if (nmi_set !== (k < 2)) begin
                fails++;
                $display("FAIL nmi_pulse%0d nmi_set=%b exp=%b",
                         k, nmi_set, (k < 2));
            end
        end
        nmi_req = 1'b0;
    endtask

    task automatic test_timeout;
        next;
        main_req = 1'b1;
        @(negedge clk);
        tests++;
        if (o !== 5'b10000) begin
            fails++;
            $display("FAIL tmo_c0 o=%b exp=10000", o);
        end
        for (int k = 1; k <= 256; k++) next;
        @(negedge clk);
        tests++;
        if (o !== 5'b11000) begin
            fails++;
            $display("FAIL tmo_c256 o=%b exp=11000", o);
        end
        next;
        @(negedge clk);
        tests++;
        if (o !== 5'b01101) begin
            fails++;
            $display("FAIL tmo_c257 o=%b exp=01101", o);
        end
        drop_to_idle();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) next;
            @(negedge clk);
            tests++;
            if (o !== 5'b00001) begin
                fails++;
                $display("FAIL tmo_sticky%0d o=%b exp=00001", k, o);
            end
        end
    endtask

    task automatic test_reset_grant;
        to_grant(1'b1);
        next;
        #2;
        rstb = 1'b0;
        #1;
        tests++;
        if (o !== 5'b10000) begin
            fails++;
            $display("FAIL rstgrant_async o=%b exp=10000", o);
        end
        main_req   = 1'b0;
        mcu_halted = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        next;
        @(negedge clk);
        tests++;
        if (o !== 5'b00000) begin
            fails++;
            $display("FAIL rstgrant_idle o=%b exp=00000", o);
        end
        next;
        main_req = 1'b1;
        next;
        @(negedge clk);
        tests++;
        if (o !== 5'b11000) begin
            fails++;
            $display("FAIL rstgrant_first o=%b exp=11000", o);
        end
        mcu_halted = 1'b1;
        next;
        @(negedge clk);
        tests++;
        if (o !== 5'b01100) begin
            fails++;
            $display("FAIL rstgrant_regrant o=%b exp=01100", o);
        end
        drop_to_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_grant();
        test_hold();
        test_release_pending();
        test_reassert();
        test_nmi();
        test_timeout();
        test_reset_grant();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
